// File: rtl/lamp_shift_driver.sv
// Serialises the parallel lamp vector into a cascaded 74HC595-style chain (sclk/sdata/slatch).
// A frame is sent only when lamp differs from the last frame sent, or when a refresh is requested.

module lamp_shift_driver #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lamp,
  input  logic             refresh,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             pend_q, pend_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             slatch_q, slatch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] seq_d;
  logic             cnt_end;

  assign cnt_end = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    // Refresh requests seen mid-frame collapse into a single pending frame.
    pend_d   = pend_q | ((state_q != StIdle) & refresh);
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((lamp != last_q) || refresh || pend_q) begin
          state_d  = StShiftLo;
          shadow_d = lamp;
          bit_d    = '0;
          cnt_d    = '0;
          pend_d   = 1'b0;
        end
      end
      StShiftLo: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = StShiftHi;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            state_d = StLatch;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StShiftLo;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = StIdle;
          last_d  = shadow_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    seq_d    = MSB_FIRST ? (shadow_d << bit_d) : (shadow_d >> bit_d);
    sclk_d   = (state_d == StShiftHi);
    slatch_d = (state_d == StLatch);
    busy_d   = (state_d != StIdle);
    sdata_d  = 1'b0;
    if ((state_d == StShiftLo) || (state_d == StShiftHi)) begin
      sdata_d = MSB_FIRST ? seq_d[WIDTH-1] : seq_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      last_q   <= '0;
      pend_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      slatch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      slatch_q <= slatch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign slatch     = slatch_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_lamp_shift_driver.sv
// Scoreboard bench for lamp_shift_driver: stimulus pushes expected frames, a monitor
// reassembles each serial frame and checks it against the queue on frame_done.

module tb_lamp_shift_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lamp;
  logic        refresh;
  logic        sclk, sdata, slatch, busy, frame_done;

  logic [15:0] lamp_l = 16'h0003;
  logic        refresh_l = 1'b0;
  logic        sclk_l, sdata_l, slatch_l, busy_l, frame_done_l;

  int total;
  int passed;

  logic [15:0] exp_q[$];

  // Monitor state for the MSB-first instance
  int          rises, latch_len, busy_len;
  logic [15:0] cap;
  logic        prev_sclk, prev_sdata;
  // Monitor state for the LSB-first instance
  int          rises_l, latch_len_l, busy_len_l;
  logic [15:0] cap_l;
  logic        prev_sclk_l;

  always #5 clk = ~clk;

  lamp_shift_driver #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .lamp       (lamp),
    .refresh    (refresh),
    .sclk       (sclk),
    .sdata      (sdata),
    .slatch     (slatch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  lamp_shift_driver #(.WIDTH(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .lamp       (lamp_l),
    .refresh    (refresh_l),
    .sclk       (sclk_l),
    .sdata      (sdata_l),
    .slatch     (slatch_l),
    .busy       (busy_l),
    .frame_done (frame_done_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL timeout_%s: got no event, want event within bound", name);
  endtask

  task automatic clear_mon();
    rises = 0; latch_len = 0; busy_len = 0; cap = '0;
    rises_l = 0; latch_len_l = 0; busy_len_l = 0; cap_l = '0;
  endtask

  // Monitor: samples on the falling edge, frames are assembled in transmission order
  initial begin : monitor
    logic [15:0] expv;
    clear_mon();
    prev_sclk = 1'b0; prev_sdata = 1'b0; prev_sclk_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        clear_mon();
        prev_sclk = 1'b0; prev_sdata = 1'b0; prev_sclk_l = 1'b0;
      end else begin
        if (prev_sclk && sclk) chk("sdata_hold", {31'd0, sdata}, {31'd0, prev_sdata});
        if (sclk && !prev_sclk) begin
          rises++;
          cap = {cap[14:0], sdata};
        end
        if (slatch) latch_len++;
        if (busy) busy_len++;
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_frame: got frame 0x%0h, want no frame", cap);
          end else begin
            expv = exp_q.pop_front();
            chk("frame_data", {16'd0, cap}, {16'd0, expv});
            chk("sclk_rises", rises, 16);
            chk("latch_len", latch_len, 4);
            chk("busy_len", busy_len, 132);
          end
          rises = 0; latch_len = 0; busy_len = 0; cap = '0;
        end
        prev_sclk  = sclk;
        prev_sdata = sdata;

        if (sclk_l && !prev_sclk_l) begin
          rises_l++;
          cap_l = {cap_l[14:0], sdata_l};
        end
        if (slatch_l) latch_len_l++;
        if (busy_l) busy_len_l++;
        if (frame_done_l) begin
          // 16'h0003 sent LSB first: ones on rises 1 and 2 only
          chk("lsb_frame", {16'd0, cap_l}, 32'h0000_C000);
          chk("lsb_rises", rises_l, 16);
          chk("lsb_latch", latch_len_l, 4);
          chk("lsb_busy", busy_len_l, 132);
          rises_l = 0; latch_len_l = 0; busy_len_l = 0; cap_l = '0;
        end
        prev_sclk_l = sclk_l;
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    int hi;
    ok = 1'b0;
    hi = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !busy && !frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_idle");
    else begin
      repeat (20) begin
        @(negedge clk); #1;
        if (busy) hi++;
      end
      chk("stays_idle", hi, 0);
    end
  endtask

  task automatic wait_rises(input int n);
    int   cnt;
    logic prev;
    bit   ok;
    cnt = 0; prev = sclk; ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (sclk && !prev) cnt++;
      prev = sclk;
      if (cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_rises");
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_done");
  endtask

  initial begin : stimulus
    int n;
    int c_sclk, c_latch, c_busy;
    bit ok;
    total = 0; passed = 0;
    rst = 1'b1; lamp = 16'h0000; refresh = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {27'd0, sclk, sdata, slatch, busy, frame_done}, 32'd0);

    // 1: auto frame of 0000 after release, frame_done on the 133rd clk
    exp_q.push_back(16'h0000);
    rst = 1'b0;
    n = 0; ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      n++;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("first_frame");
    else chk("first_done_latency", n, 133);
    wait_idle();

    // 2: 8001 -> ones at rises 1 and 16
    lamp = 16'h8001;
    exp_q.push_back(16'h8001);
    wait_idle();

    // 3: unchanged lamp for 500 clks -> no activity
    c_sclk = 0; c_latch = 0; c_busy = 0;
    repeat (500) begin
      @(negedge clk); #1;
      if (sclk) c_sclk++;
      if (slatch) c_latch++;
      if (busy) c_busy++;
    end
    chk("idle_sclk", c_sclk, 0);
    chk("idle_slatch", c_latch, 0);
    chk("idle_busy", c_busy, 0);

    // 4: lamp changes mid-frame; first frame intact, second follows back-to-back
    lamp = 16'h00FF;
    exp_q.push_back(16'h00FF);
    wait_rises(5);
    lamp = 16'hFF00;
    exp_q.push_back(16'hFF00);
    wait_done(ok);
    if (ok) begin
      chk("done_busy_low", {31'd0, busy}, 32'd0);
      @(negedge clk); #1;
      chk("busy_rerise", {31'd0, busy}, 32'd1);
      chk("done_one_clk", {31'd0, frame_done}, 32'd0);
    end
    wait_idle();

    // 5: reset during bit 7 high phase; partial frame dropped, full frame after release
    lamp = 16'h1234;
    exp_q.push_back(16'h1234);
    wait_rises(8);
    chk("pre_rst_sclk", {31'd0, sclk}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", {28'd0, sclk, sdata, slatch, busy}, 32'd0);
    chk("partial_latch", latch_len, 0);
    exp_q.delete();
    lamp = 16'h5A5A;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_held_slatch", {31'd0, slatch}, 32'd0);
    exp_q.push_back(16'h5A5A);
    rst = 1'b0;
    wait_idle();

    // 6: refresh pulse with unchanged lamp -> one frame
    refresh = 1'b1;
    exp_q.push_back(16'h5A5A);
    @(negedge clk); #1;
    refresh = 1'b0;
    wait_idle();

    // 6b: refresh held 10 clks mid-frame -> exactly one extra frame
    refresh = 1'b1;
    exp_q.push_back(16'h5A5A);
    @(negedge clk); #1;
    refresh = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    refresh = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    refresh = 1'b0;
    exp_q.push_back(16'h5A5A);
    wait_idle();

    // Refresh together with a lamp change in idle -> one frame only
    lamp = 16'h0F0F;
    refresh = 1'b1;
    exp_q.push_back(16'h0F0F);
    @(negedge clk); #1;
    refresh = 1'b0;
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
